prio_enc_rr: RTL

PRIO_ENC_RR -- requirements
Module: prio_enc_rr

---
 rtl/prio_enc_rr.sv | 113 +++++++++++
 1 files changed

// File: rtl/prio_enc_rr.sv
// Priority encoder with a pending-request register, a registered
// valid/ready output, and selectable fixed or round-robin arbitration.
//
// Parameters:
//   N  number of request sources (2..256)
//   W  index width, derived from N (do not override)
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   en       1 = capture req into pending this edge
//   mode     0 = fixed priority (highest index), 1 = round-robin
//   req      request vector, one bit per source
//   out_idx  registered index of the selected source
//   out_vld  out_idx holds a valid selection
//   out_rdy  consumer accepts out_idx this cycle
//   busy     registered OR of the pending bits
module prio_enc_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_idx,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         busy
);

  localparam int NI = int'(N);

  logic [N-1:0] r_pending;
  logic [W-1:0] r_out_idx;
  logic         r_out_vld;
  logic [W-1:0] r_ptr;
  logic         r_busy;

  logic         w_free;
  logic         w_load;
  logic [W-1:0] w_start;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_rr_idx;
  logic [W-1:0] w_sel;
  logic [N-1:0] w_load_mask;
  logic [N-1:0] w_pending_d;

  assign w_free = !r_out_vld || out_rdy;
  assign w_load = w_free && (|r_pending);

  // Round-robin scan begins just past the last loaded index; the explicit
  // wrap keeps non-power-of-two N from ever reaching an index >= N.
  assign w_start = (r_ptr == W'(N - 1)) ? '0 : r_ptr + 1'b1;

  // Fixed priority: ascending scan, the last hit is the highest set bit.
  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < NI; i++) begin
      if (r_pending[i]) begin
        w_hi_idx = W'(i);
      end
    end
  end

  // Round-robin: descending offset scan, the last hit is the first set bit
  // at or after w_start in circular order.
  always_comb begin
    int pos;
    pos      = 0;
    w_rr_idx = '0;
    for (int i = NI - 1; i >= 0; i--) begin
      pos = int'(w_start) + i;
      if (pos >= NI) begin
        pos = pos - NI;
      end
      if (r_pending[pos]) begin
        w_rr_idx = W'(pos);
      end
    end
  end

  assign w_sel       = mode ? w_rr_idx : w_hi_idx;
  assign w_load_mask = w_load ? ({{(N - 1){1'b0}}, 1'b1} << w_sel) : '0;

  // A new request on the same edge as its load re-sets the bit.
  assign w_pending_d = (r_pending & ~w_load_mask) | (en ? req : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_out_idx <= '0;
      r_out_vld <= 1'b0;
      r_ptr     <= W'(N - 1);
      r_busy    <= 1'b0;
    end else begin
      r_pending <= w_pending_d;
      r_busy    <= |w_pending_d;
      if (w_free) begin
        r_out_vld <= w_load;
      end
      if (w_load) begin
        r_out_idx <= w_sel;
        r_ptr     <= w_sel;
      end
    end
  end

  assign out_idx = r_out_idx;
  assign out_vld = r_out_vld;
  assign busy    = r_busy;

endmodule
